// File: rtl/produce_spawner_if.sv
// Spawn request channel from the spawner to the produce/object manager.
// A request transfers on any rising clk edge where spawn_valid && spawn_ready are both high.
// Once spawn_valid rises it stays high, with x/type/speed stable, until that transfer.
interface produce_spawner_if;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [9:0] spawn_x;
    logic [2:0] spawn_type;
    logic [2:0] spawn_speed;
    logic [7:0] spawn_count;

    modport master (
        output spawn_valid, spawn_x, spawn_type, spawn_speed, spawn_count,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid, spawn_x, spawn_type, spawn_speed, spawn_count,
        output spawn_ready
    );
endinterface

// File: rtl/produce_spawner.sv
// Turns the LFSR byte stream into frame-timed spawn requests (x, type, speed).
// The LFSR byte arrives on rand_byte because "rand" is a reserved word in SystemVerilog.
module produce_spawner #(
    parameter int X_MIN    = 64,
    parameter int MIN_GAP  = 8,
    parameter int GAP_STEP = 4,
    parameter int INIT_GAP = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               frame_tick,
    input  logic               enable,
    input  logic [7:0]         rand_byte,
    output logic [2:0]         fsm_state,
    produce_spawner_if.master  spawn
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        SAMPLE_A = 3'd2,
        SAMPLE_B = 3'd3,
        OFFER    = 3'd4
    } state_t;

    localparam logic [9:0] X_MIN_W    = 10'(X_MIN);
    localparam logic [7:0] MIN_GAP_B  = 8'(MIN_GAP);
    localparam logic [7:0] GAP_STEP_B = 8'(GAP_STEP);
    localparam logic [7:0] INIT_GAP_B = 8'(INIT_GAP);

    state_t     state, state_next;
    logic [7:0] gap_cnt;
    logic [7:0] next_gap;
    logic [9:0] x_q;
    logic [2:0] type_q;
    logic [2:0] speed_q;
    logic [7:0] count_q;

    logic load_init, load_next, dec, cap_a, cap_b, handshake;

    always_comb begin
        state_next = state;
        load_init  = 1'b0;
        load_next  = 1'b0;
        dec        = 1'b0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        handshake  = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT;
                    load_init  = 1'b1;
                end
            end
            WAIT: begin
                // Dropping enable wins over a final tick in the same cycle.
                if (!enable) begin
                    state_next = IDLE;
                end else if (frame_tick) begin
                    dec = 1'b1;
                    if (gap_cnt == 8'd1) state_next = SAMPLE_A;
                end
            end
            SAMPLE_A: begin
                cap_a      = 1'b1;
                state_next = SAMPLE_B;
            end
            SAMPLE_B: begin
                cap_b      = 1'b1;
                state_next = OFFER;
            end
            OFFER: begin
                if (spawn.spawn_ready) begin
                    handshake  = 1'b1;
                    load_next  = 1'b1;
                    state_next = enable ? WAIT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gap_cnt  <= 8'd0;
            next_gap <= 8'd0;
            x_q      <= 10'd0;
            type_q   <= 3'd0;
            speed_q  <= 3'd0;
            count_q  <= 8'd0;
        end else begin
            if (load_init)      gap_cnt <= INIT_GAP_B;
            else if (load_next) gap_cnt <= next_gap;
            else if (dec)       gap_cnt <= gap_cnt - 8'd1;

            if (cap_a) x_q <= X_MIN_W + {1'b0, rand_byte, 1'b0};

            // Second byte supplies type, speed (0 promoted to 1) and the following gap.
            if (cap_b) begin
                type_q   <= rand_byte[2:0];
                speed_q  <= (rand_byte[5:3] == 3'd0) ? 3'd1 : rand_byte[5:3];
                next_gap <= MIN_GAP_B + GAP_STEP_B * {6'd0, rand_byte[7:6]};
            end

            if (handshake) count_q <= count_q + 8'd1;
        end
    end

    assign spawn.spawn_valid = (state == OFFER);
    assign spawn.spawn_x     = x_q;
    assign spawn.spawn_type  = type_q;
    assign spawn.spawn_speed = speed_q;
    assign spawn.spawn_count = count_q;
    assign fsm_state         = state;
endmodule

// File: tb/tb_produce_spawner.sv
// Bench for produce_spawner: directed timing/boundary cases, then randomized traffic
// checked against a frame-counting reference model through an expected-offer queue.
module tb_produce_spawner;
    localparam int X_MIN    = 64;
    localparam int MIN_GAP  = 8;
    localparam int GAP_STEP = 4;
    localparam int INIT_GAP = 4;

    logic       clk;
    logic       clr;
    logic       frame_tick;
    logic       enable;
    logic [7:0] rand_byte;
    logic [2:0] fsm_state;

    produce_spawner_if sif ();

    produce_spawner dut (
        .clk        (clk),
        .clr        (clr),
        .frame_tick (frame_tick),
        .enable     (enable),
        .rand_byte  (rand_byte),
        .fsm_state  (fsm_state),
        .spawn      (sif.master)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not as required", name);
    endtask

    // ---------------- reference model ----------------
    // Offer word: {cycle[31:0], x[9:0], type[2:0], speed[2:0]}
    logic [47:0] exp_q[$];
    logic [7:0]  cnt_q[$];
    int cyc = 0;
    int hs_total = 0;

    int   m_mode  = 0;    // 0 idle, 1 counting frames, 2 request in flight
    int   m_left  = 0;
    int   m_age   = 0;    // cycles since the final frame of a gap
    bit   m_offer = 0;
    int   m_a     = 0;
    int   m_next  = 0;
    int   m_count = 0;

    task automatic model_step();
        int b, x, t, s;
        cyc++;
        if (clr) begin
            m_mode = 0; m_left = 0; m_age = 0; m_offer = 0;
            m_next = 0; m_count = 0; hs_total = 0;
            exp_q.delete();
            cnt_q.delete();
            return;
        end
        if (m_offer && sif.spawn_ready) begin
            m_offer = 0;
            m_count = (m_count + 1) % 256;
            hs_total++;
            cnt_q.push_back(8'(m_count));
            m_left = m_next;
            m_mode = enable ? 1 : 0;
        end else if (m_age == 1) begin
            m_a   = int'(rand_byte);
            m_age = 2;
        end else if (m_age == 2) begin
            b = int'(rand_byte);
            x = X_MIN + 2 * m_a;
            t = b % 8;
            s = (b / 8) % 8;
            if (s == 0) s = 1;
            m_next = MIN_GAP + (b / 64) * GAP_STEP;
            exp_q.push_back({32'(cyc), 10'(x), 3'(t), 3'(s)});
            m_offer = 1;
            m_age   = 0;
        end else if (m_mode == 0) begin
            if (enable) begin
                m_mode = 1;
                m_left = INIT_GAP;
            end
        end else if (m_mode == 1) begin
            if (!enable) begin
                m_mode = 0;
            end else if (frame_tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_age  = 1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- monitor / scoreboard ----------------
    bit          in_offer = 0;
    bit          hs_pend  = 0;
    logic [47:0] cur      = '0;

    initial forever begin
        @(negedge clk);
        if (clr) begin
            in_offer = 0;
            hs_pend  = 0;
        end else begin
            if (hs_pend) begin
                hs_pend  = 0;
                in_offer = 0;
                check("valid_after_handshake", int'(sif.spawn_valid), 0);
                if (cnt_q.size() == 0) fail_now("count_without_handshake");
                else check("spawn_count", int'(sif.spawn_count), int'(cnt_q.pop_front()));
            end
            if (sif.spawn_valid) begin
                if (!in_offer) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_valid");
                    end else begin
                        cur = exp_q.pop_front();
                        check("offer_cycle", cyc, int'(cur[47:16]));
                        check("spawn_x", int'(sif.spawn_x), int'(cur[15:6]));
                        check("spawn_type", int'(sif.spawn_type), int'(cur[5:3]));
                        check("spawn_speed", int'(sif.spawn_speed), int'(cur[2:0]));
                    end
                    in_offer = 1;
                end else begin
                    check("hold_x", int'(sif.spawn_x), int'(cur[15:6]));
                    check("hold_type", int'(sif.spawn_type), int'(cur[5:3]));
                    check("hold_speed", int'(sif.spawn_speed), int'(cur[2:0]));
                end
                if (sif.spawn_ready) hs_pend = 1;
            end else if (in_offer) begin
                fail_now("valid_dropped_without_handshake");
                in_offer = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic tick, input logic [7:0] r);
        frame_tick = tick;
        rand_byte  = r;
        @(posedge clk);
        #1;
    endtask

    // Tick every cycle until spawn_valid is seen; edges counts clock edges taken.
    task automatic wait_valid(input bit use_const, input logic [7:0] r, output int edges);
        edges = 0;
        while (1) begin
            drive(1'b1, use_const ? r : 8'($urandom_range(0, 255)));
            edges++;
            if (sif.spawn_valid) break;
            if (edges >= 200) begin
                fail_now("wait_valid_timeout");
                break;
            end
        end
    endtask

    task automatic quiet(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)));
            if (sif.spawn_valid) seen++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(sif.spawn_valid), 0);
        check({tag, "_x"}, int'(sif.spawn_x), 0);
        check({tag, "_type"}, int'(sif.spawn_type), 0);
        check({tag, "_speed"}, int'(sif.spawn_speed), 0);
        check({tag, "_count"}, int'(sif.spawn_count), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int edges, seen, stall_valid, guard;
        clr = 1'b0; enable = 1'b0; frame_tick = 1'b0; rand_byte = 8'd0;
        sif.spawn_ready = 1'b0;
        #1 clr = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        clr = 1'b0;

        // One handshake so the count is non-zero, then clr in the middle of an offer.
        enable = 1'b1; sif.spawn_ready = 1'b1;
        drive(1'b0, 8'($urandom_range(0, 255)));
        wait_valid(1'b0, 8'd0, edges);
        check("init_gap_edges", edges, INIT_GAP + 2);
        drive(1'b0, 8'($urandom_range(0, 255)));
        check("first_count", int'(sif.spawn_count), 1);
        sif.spawn_ready = 1'b0;
        wait_valid(1'b0, 8'd0, edges);
        #1 clr = 1'b1;
        #1 check_all_zero("clr_mid_offer");
        enable = 1'b0;
        drive(1'b0, 8'd0);
        drive(1'b0, 8'd0);
        clr = 1'b0;
        quiet(20, seen);
        check("idle_after_clr", seen, 0);

        // First spawn with fixed bytes: 0x80 at SAMPLE_A, 0xC7 at SAMPLE_B.
        enable = 1'b1; sif.spawn_ready = 1'b1;
        drive(1'b0, 8'd0);
        for (int i = 0; i < INIT_GAP; i++) drive(1'b1, 8'($urandom_range(0, 255)));
        drive(1'b0, 8'h80);
        drive(1'b0, 8'hC7);
        check("first_valid", int'(sif.spawn_valid), 1);
        check("first_x", int'(sif.spawn_x), 320);
        check("first_type", int'(sif.spawn_type), 7);
        check("first_speed", int'(sif.spawn_speed), 1);
        drive(1'b0, 8'd0);
        check("first_valid_pulse", int'(sif.spawn_valid), 0);
        check("first_count_after_clr", int'(sif.spawn_count), 1);

        // Gap of 20 frames, then x lower bound and an 8-frame gap, then upper bound.
        wait_valid(1'b1, 8'h00, edges);
        check("gap20_edges", edges, 20 + 2);
        check("xmin_x", int'(sif.spawn_x), 64);
        check("xmin_speed", int'(sif.spawn_speed), 1);
        drive(1'b0, 8'd0);
        wait_valid(1'b1, 8'hFF, edges);
        check("gap8_edges", edges, 8 + 2);
        check("xmax_x", int'(sif.spawn_x), 574);
        check("xmax_type", int'(sif.spawn_type), 7);
        check("xmax_speed", int'(sif.spawn_speed), 7);
        drive(1'b0, 8'd0);
        wait_valid(1'b1, 8'h00, edges);
        check("gap20b_edges", edges, 20 + 2);

        // Backpressure: 50 stalled cycles with 5 ticks; the gap restarts at the handshake.
        sif.spawn_ready = 1'b0;
        stall_valid = 0;
        for (int i = 0; i < 50; i++) begin
            drive((i % 10) == 0, 8'($urandom_range(0, 255)));
            if (sif.spawn_valid) stall_valid++;
        end
        check("stall_valid_cycles", stall_valid, 50);
        sif.spawn_ready = 1'b1;
        drive(1'b0, 8'd0);
        wait_valid(1'b0, 8'd0, edges);
        check("gap_after_stall_edges", edges, 8 + 2);

        // enable dropped in WAIT.
        drive(1'b0, 8'd0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom_range(0, 255)));
        enable = 1'b0;
        quiet(30, seen);
        check("en_drop_wait", seen, 0);

        // enable dropped together with the final tick.
        enable = 1'b1;
        drive(1'b0, 8'd0);
        for (int i = 0; i < INIT_GAP - 1; i++) drive(1'b1, 8'($urandom_range(0, 255)));
        enable = 1'b0;
        drive(1'b1, 8'($urandom_range(0, 255)));
        quiet(20, seen);
        check("en_drop_final_tick", seen, 0);
        enable = 1'b1;
        drive(1'b0, 8'd0);
        wait_valid(1'b0, 8'd0, edges);
        check("init_gap_again_edges", edges, INIT_GAP + 2);

        // enable dropped during OFFER: request still completes, then idle.
        sif.spawn_ready = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom_range(0, 255)));
        check("offer_survives_enable_low", int'(sif.spawn_valid), 1);
        sif.spawn_ready = 1'b1;
        drive(1'b0, 8'd0);
        quiet(30, seen);
        check("en_drop_offer", seen, 0);

        // Randomized traffic until the spawn counter has wrapped.
        enable = 1'b1;
        guard = 0;
        while (hs_total < 270 && guard < 40000) begin
            sif.spawn_ready = ($urandom_range(0, 3) != 0);
            if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            else if ($urandom_range(0, 199) == 0) enable = 1'b0;
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            guard++;
        end
        check("wrap_reached", int'(hs_total >= 270), 1);

        enable = 1'b0; sif.spawn_ready = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b0, 8'd0);
        check("exp_queue_drained", exp_q.size(), 0);
        check("count_queue_drained", cnt_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
